// File: rtl/cim_core_macro_mem_bridge_if.sv
// rtl/cim_core_macro_mem_bridge_if.sv - request/response and macro memory port bundle for the CIM bridge
interface cim_core_macro_mem_bridge_if #(
    parameter int AW = 64,
    parameter int DW = 64
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_we_i;
    logic [AW-1:0]     req_addr_i;
    logic [DW/8-1:0]   req_be_i;
    logic [DW-1:0]     req_wdata_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic              rsp_we_o;
    logic [DW-1:0]     rsp_rdata_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [AW-1:0]     mem_addr_o;
    logic [DW/8-1:0]   mem_be_o;
    logic [DW-1:0]     mem_data_o;
    logic [DW-1:0]     mem_data_i;
    logic              busy_o;

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_be_i, req_wdata_i,
        input  rsp_ready_i, mem_data_i,
        output req_ready_o, rsp_valid_o, rsp_we_o, rsp_rdata_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_data_o, busy_o
    );

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_be_i, req_wdata_i,
        output rsp_ready_i, mem_data_i,
        input  req_ready_o, rsp_valid_o, rsp_we_o, rsp_rdata_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_data_o, busy_o
    );
endinterface

// File: rtl/cim_core_macro_mem_bridge.sv
// rtl/cim_core_macro_mem_bridge.sv - valid/ready to single-cycle macro port bridge with credit-protected in-order response FIFO
module cim_core_macro_mem_bridge #(
    parameter int MEM_ADDR_WIDTH = 64,
    parameter int MEM_DATA_WIDTH = 64,
    parameter int RD_LATENCY     = 1,
    parameter int RSP_DEPTH      = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    cim_core_macro_mem_bridge_if.slave   bus
);
    localparam int CW = $clog2(RSP_DEPTH) + 1;
    localparam int PW = $clog2(RSP_DEPTH);

    logic [RD_LATENCY-1:0]     r_pipe_vld;
    logic [RD_LATENCY-1:0]     r_pipe_we;
    logic [CW-1:0]             r_inflight_cnt;
    logic [CW-1:0]             r_fifo_cnt;
    logic [PW-1:0]             r_wr_ptr;
    logic [PW-1:0]             r_rd_ptr;
    logic                      r_fifo_we   [RSP_DEPTH];
    logic [MEM_DATA_WIDTH-1:0] r_fifo_data [RSP_DEPTH];

    logic          w_ready;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic [CW-1:0] w_occupancy;

    // Every slot counted here is either queued or already promised to an in-flight access.
    assign w_occupancy = r_fifo_cnt + r_inflight_cnt;
    assign w_ready     = rst_ni && (w_occupancy < CW'(RSP_DEPTH));
    assign w_accept    = bus.req_valid_i && w_ready;
    assign w_push      = r_pipe_vld[RD_LATENCY-1];
    assign w_empty     = (r_fifo_cnt == '0);
    assign w_pop       = !w_empty && bus.rsp_ready_i;

    assign bus.req_ready_o = w_ready;
    assign bus.mem_req_o   = w_accept;
    assign bus.mem_addr_o  = bus.req_addr_i;
    assign bus.mem_we_o    = w_accept && bus.req_we_i;
    assign bus.mem_be_o    = w_accept ? bus.req_be_i    : '0;
    assign bus.mem_data_o  = w_accept ? bus.req_wdata_i : '0;

    assign bus.rsp_valid_o = !w_empty;
    assign bus.rsp_we_o    = w_empty ? 1'b0 : r_fifo_we[r_rd_ptr];
    assign bus.rsp_rdata_o = w_empty ? '0   : r_fifo_data[r_rd_ptr];
    assign bus.busy_o      = (r_inflight_cnt != '0) || !w_empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pipe_vld     <= '0;
            r_pipe_we      <= '0;
            r_inflight_cnt <= '0;
        end else begin
            r_pipe_vld[0] <= w_accept;
            r_pipe_we[0]  <= w_accept && bus.req_we_i;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_we[i]  <= r_pipe_we[i-1];
            end
            r_inflight_cnt <= r_inflight_cnt + CW'(w_accept) - CW'(w_push);
        end
    end

    // Writes travel the same pipe so their acks stay ordered behind earlier reads.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fifo_cnt <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                r_fifo_we[i]   <= 1'b0;
                r_fifo_data[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_fifo_we[r_wr_ptr]   <= r_pipe_we[RD_LATENCY-1];
                r_fifo_data[r_wr_ptr] <= r_pipe_we[RD_LATENCY-1] ? '0 : bus.mem_data_i;
                r_wr_ptr              <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_fifo_cnt <= r_fifo_cnt + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule

// File: tb/tb_cim_core_macro_mem_bridge.sv
// tb/tb_cim_core_macro_mem_bridge.sv - scoreboard bench for the CIM macro memory bridge
module tb_cim_core_macro_mem_bridge;
    localparam int AW = 64;
    localparam int DW = 64;

    typedef struct packed {
        logic          we;
        logic [DW-1:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_acc = 0;
    int   cyc = 0;
    rsp_t sb[$];
    int   rsp_cyc[$];
    logic          rd_pend = 1'b0;
    logic [AW-1:0] rd_addr = '0;

    cim_core_macro_mem_bridge_if #(.AW(AW), .DW(DW)) bus ();

    cim_core_macro_mem_bridge #(
        .MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW), .RD_LATENCY(1), .RSP_DEPTH(4)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_ni),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
        if (a == 64'h1000) return 64'hDEADBEEF_CAFEF00D;
        return {a[31:0] ^ 32'h1357_9BDF, a[31:0] * 32'h9E37_79B1};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Macro model: read data is valid for the whole cycle after the issue cycle, junk otherwise.
    always @(negedge clk) begin
        rd_pend <= rst_ni && bus.mem_req_o && !bus.mem_we_o;
        rd_addr <= bus.mem_addr_o;
    end
    always @(posedge clk) begin
        bus.mem_data_i <= rd_pend ? mem_model(rd_addr) : {$urandom, $urandom};
    end

    always @(negedge clk) begin
        if (rst_ni && bus.mem_req_o) n_acc <= n_acc + 1;
        if (rst_ni && bus.rsp_valid_o && bus.rsp_ready_i) begin
            rsp_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                rsp_t e;
                e = sb.pop_front();
                chk("rsp_we", bus.rsp_we_o, e.we);
                chk("rsp_rdata", bus.rsp_rdata_o, e.data);
            end
        end
    end

    task automatic send(input logic we, input logic [AW-1:0] addr, input logic [7:0] be,
                        input logic [DW-1:0] wd, output int waits);
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = we;
        bus.req_addr_i  = addr;
        bus.req_be_i    = be;
        bus.req_wdata_i = wd;
        waits = 0;
        @(negedge clk);
        while (!bus.req_ready_o && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!bus.req_ready_o) begin
            chk("send_timeout", 0, 1);
        end else begin
            chk("mem_req", bus.mem_req_o, 1);
            chk("mem_we", bus.mem_we_o, we);
            chk("mem_addr", bus.mem_addr_o, addr);
            chk("mem_be", bus.mem_be_o, be);
            chk("mem_data", bus.mem_data_o, wd);
            sb.push_back('{we: we, data: we ? '0 : mem_model(addr)});
        end
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
        bus.req_we_i    = 1'b0;
    endtask

    task automatic lat(input string tag);
        @(negedge clk);
        chk({tag, "_early"}, bus.rsp_valid_o, 0);
        @(negedge clk);
        chk({tag, "_due"}, bus.rsp_valid_o, 1);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while ((sb.size() != 0 || bus.busy_o) && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_drained"}, sb.size(), 0);
        chk({tag, "_busy"}, bus.busy_o, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        int a0;
        int base;
        bit done;
        bus.req_valid_i = 1'b0;
        bus.req_we_i    = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_be_i    = '0;
        bus.req_wdata_i = '0;
        bus.rsp_ready_i = 1'b0;

        // T1: reset with random inputs
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            bus.req_valid_i = 1'($urandom);
            bus.req_we_i    = 1'($urandom);
            bus.req_addr_i  = {$urandom, $urandom};
            bus.req_be_i    = 8'($urandom);
            bus.req_wdata_i = {$urandom, $urandom};
            bus.rsp_ready_i = 1'($urandom);
            @(negedge clk);
            chk("t1_rsp_valid", bus.rsp_valid_o, 0);
            chk("t1_busy", bus.busy_o, 0);
            chk("t1_mem_req", bus.mem_req_o, 0);
            chk("t1_mem_we", bus.mem_we_o, 0);
            chk("t1_rsp_rdata", bus.rsp_rdata_o, 0);
        end
        bus.req_valid_i = 1'b0;
        bus.rsp_ready_i = 1'b1;
        #1 rst_ni = 1'b1;
        #1 chk("t1_ready_after_release", bus.req_ready_o, 1);
        @(posedge clk);
        #1;

        // T2: single read latency
        send(1'b0, 64'h1000, 8'hFF, 64'h0, w);
        lat("t2_rsp_valid");
        wait_idle("t2");

        // T3: 8 back-to-back reads
        base = rsp_cyc.size();
        for (int i = 0; i < 8; i++) begin
            send(1'b0, 64'h3000 + 64'(i * 8), 8'hFF, 64'h0, w);
            chk("t3_stall", w, 0);
        end
        wait_idle("t3");
        chk("t3_rsp_count", rsp_cyc.size() - base, 8);
        if (rsp_cyc.size() - base == 8) chk("t3_rsp_span", rsp_cyc[base+7] - rsp_cyc[base], 7);

        // T4: backpressure, credits exhaust at 4
        bus.rsp_ready_i = 1'b0;
        a0 = n_acc;
        for (int i = 0; i < 4; i++) send(1'b0, 64'h4000 + 64'(i * 8), 8'hFF, 64'h0, w);
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = 64'h4020;
        repeat (3) begin
            @(negedge clk);
            chk("t4_ready_blocked", bus.req_ready_o, 0);
            chk("t4_mem_req_blocked", bus.mem_req_o, 0);
        end
        chk("t4_accepted", n_acc - a0, 4);
        bus.rsp_ready_i = 1'b1;
        send(1'b0, 64'h4020, 8'hFF, 64'h0, w);
        wait_idle("t4");
        chk("t4_total_accepted", n_acc - a0, 5);

        // T5: write ack
        send(1'b1, 64'h2008, 8'hF0, 64'h1122334455667788, w);
        lat("t5_ack_valid");
        wait_idle("t5");

        // T6: asynchronous reset with work outstanding
        bus.rsp_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) send(1'b0, 64'h6000 + 64'(i * 8), 8'hFF, 64'h0, w);
        chk("t6_busy_before", bus.busy_o, 1);
        @(negedge clk);
        #1 rst_ni = 1'b0;
        #1;
        chk("t6_busy_in_reset", bus.busy_o, 0);
        chk("t6_valid_in_reset", bus.rsp_valid_o, 0);
        sb.delete();
        #1 rst_ni = 1'b1;
        bus.rsp_ready_i = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("t6_no_stale", bus.rsp_valid_o, 0);
        end
        @(posedge clk);
        #1;
        send(1'b0, 64'h1000, 8'hFF, 64'h0, w);
        lat("t6_new_rsp");
        wait_idle("t6");

        // Random mix with random response backpressure
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    logic we;
                    we = 1'($urandom);
                    send(we, {32'h0, $urandom} & ~64'h7, 8'($urandom), {$urandom, $urandom}, w);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #2;
                    bus.rsp_ready_i = 1'($urandom);
                end
                bus.rsp_ready_i = 1'b1;
            end
        join
        wait_idle("rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
